// File: rtl/rice_bus_pkg.sv
// Shared rice_bus definitions: response and pipeline-entry type macros keyed on XLEN,
// status codes and the byte-lane alignment helper used by the memory slave.
`ifndef RICE_BUS_PKG_SV
`define RICE_BUS_PKG_SV

`define RICE_BUS_RESPONSE_T(W) struct packed { logic [(W)-1:0] data; logic error; }
`define RICE_BUS_PIPE_ENTRY_T(W) struct packed { logic valid; logic write; logic error; logic [(W)-1:0] data; }

package rice_bus_pkg;

    localparam logic RICE_BUS_ERROR = 1'b1;
    localparam logic RICE_BUS_OKAY  = 1'b0;

    // True when any enabled byte lane lies below the byte offset of the address.
    function automatic logic strobe_below_offset(input logic [7:0] strobe, input logic [2:0] offset);
        return |(strobe & ~(8'hFF << offset));
    endfunction

endpackage

`endif

// File: rtl/rice_bus_response_fifo.sv
// Synchronous response FIFO with a registered head: the head register is loaded with
// the entry that will be at the front after this cycle's push/pop, so outputs are flops.
module rice_bus_response_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head_valid,
    output T     head_data
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T           mem_r [DEPTH];
    logic [IW:0] wr_ptr_r;
    logic [IW:0] rd_ptr_r;
    logic [IW:0] wr_nxt_s;
    logic [IW:0] rd_nxt_s;
    logic        push_ok_s;
    logic        pop_ok_s;
    logic        empty_nxt_s;
    T            head_nxt_s;

    // Index wraps modulo DEPTH; the top bit flips on wrap to tell full from empty.
    function automatic logic [IW:0] ptr_inc(input logic [IW:0] ptr);
        if (ptr[IW-1:0] == IW'(DEPTH - 1)) begin
            return {~ptr[IW], {IW{1'b0}}};
        end else begin
            return ptr + {{IW{1'b0}}, 1'b1};
        end
    endfunction

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[IW-1:0] == rd_ptr_r[IW-1:0]) && (wr_ptr_r[IW] != rd_ptr_r[IW]);
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Next pointers and the entry that becomes the head after this cycle.
    always_comb begin
        wr_nxt_s    = wr_ptr_r;
        rd_nxt_s    = rd_ptr_r;
        head_nxt_s  = '0;
        if (push_ok_s) begin
            wr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_nxt_s = wr_ptr_r;
        end
        if (pop_ok_s) begin
            rd_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        empty_nxt_s = (wr_nxt_s == rd_nxt_s);
        if (empty_nxt_s) begin
            head_nxt_s = '0;
        end else if (push_ok_s && (wr_ptr_r[IW-1:0] == rd_nxt_s[IW-1:0])) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s[IW-1:0]];
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[IW-1:0]] <= push_data;
        end
    end

    // Pointers and registered head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            wr_ptr_r   <= wr_nxt_s;
            rd_ptr_r   <= rd_nxt_s;
            head_valid <= !empty_nxt_s;
            head_data  <= head_nxt_s;
        end
    end

endmodule

// File: rtl/rice_bus_memory_slave.sv
// Word-organised SRAM slave on rice_bus with fixed read latency and response FIFO.
// Optional strobe/offset alignment check: define RICE_BUS_MEMORY_SLAVE_MISALIGN_CHECK_EN.
module rice_bus_memory_slave
    import rice_bus_pkg::*;
#(
    parameter int                       XLEN          = 32,
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DEPTH         = 1024,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0,
    parameter int                       READ_LATENCY  = 1,
    parameter int                       FIFO_DEPTH    = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     request_valid,
    output logic                     request_ready,
    input  logic [ADDRESS_WIDTH-1:0] request_address,
    input  logic                     request_write,
    input  logic [XLEN-1:0]          request_data,
    input  logic [XLEN/8-1:0]        request_strobe,
    output logic                     response_valid,
    input  logic                     response_ready,
    output logic [XLEN-1:0]          response_data,
    output logic                     response_error
);

    localparam int SW   = XLEN / 8;
    localparam int OFFB = $clog2(SW);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    typedef `RICE_BUS_PIPE_ENTRY_T(XLEN) pipe_entry_t;
    typedef `RICE_BUS_RESPONSE_T(XLEN) rice_bus_response;

    logic [XLEN-1:0]          mem_r [DEPTH];
    logic                     accept_s;
    logic                     range_err_s;
    logic                     misalign_s;
    logic                     req_err_s;
    logic                     pop_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [ADDRESS_WIDTH-1:0] offset_s;
    logic [ADDRESS_WIDTH-1:0] word_s;
    logic [AW-1:0]            index_s;
    logic [CW-1:0]            outstanding_r;
    pipe_entry_t              stage0_s;
    pipe_entry_t              last_s;
    rice_bus_response         push_resp_s;
    rice_bus_response         head_s;

    // Outstanding covers pipeline plus FIFO, so the FIFO can never overflow.
    assign request_ready = !i_rst && !fifo_full_s && (outstanding_r < CW'(FIFO_DEPTH));
    assign accept_s      = request_valid && request_ready;
    assign offset_s      = request_address - BASE_ADDRESS;
    assign word_s        = offset_s >> OFFB;
    assign index_s       = word_s[AW-1:0];
    assign range_err_s   = (request_address < BASE_ADDRESS) || (word_s >= ADDRESS_WIDTH'(DEPTH));

`ifdef RICE_BUS_MEMORY_SLAVE_MISALIGN_CHECK_EN
    assign misalign_s = strobe_below_offset(8'(request_strobe), 3'(request_address[OFFB-1:0]));
`else
    assign misalign_s = 1'b0;
`endif

    // Stage 0: classify the request and read the array (captured by the next register).
    always_comb begin
        stage0_s = '0;
        if (range_err_s || misalign_s) begin
            req_err_s = RICE_BUS_ERROR;
        end else begin
            req_err_s = RICE_BUS_OKAY;
        end
        stage0_s.valid = accept_s;
        stage0_s.write = request_write;
        stage0_s.error = req_err_s;
        if (req_err_s == RICE_BUS_OKAY) begin
            stage0_s.data = mem_r[index_s];
        end else begin
            stage0_s.data = '0;
        end
    end

    // Store commit in the accept cycle, byte lanes per strobe; array is never reset.
    always_ff @(posedge i_clk) begin
        if (accept_s && request_write && (req_err_s == RICE_BUS_OKAY)) begin
            for (int b = 0; b < SW; b++) begin
                if (request_strobe[b]) begin
                    mem_r[index_s][8*b +: 8] <= request_data[8*b +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY > 1) begin : g_pipe
            pipe_entry_t pipe_r [READ_LATENCY-1];

            // Delay-only stages after the array read.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < READ_LATENCY - 1; i++) begin
                        pipe_r[i] <= '0;
                    end
                end else begin
                    pipe_r[0] <= stage0_s;
                    for (int i = 1; i < READ_LATENCY - 1; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign last_s = pipe_r[READ_LATENCY-2];
        end else begin : g_direct
            assign last_s = stage0_s;
        end
    endgenerate

    // Stores and errors answer with zero data.
    always_comb begin
        push_resp_s       = '0;
        push_resp_s.error = last_s.error;
        if (last_s.write || last_s.error) begin
            push_resp_s.data = '0;
        end else begin
            push_resp_s.data = last_s.data;
        end
    end

    rice_bus_response_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (rice_bus_response)
    ) u_response_fifo (
        .clk        (i_clk),
        .rst        (i_rst),
        .push       (last_s.valid),
        .push_data  (push_resp_s),
        .pop        (pop_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .head_valid (response_valid),
        .head_data  (head_s)
    );

    assign pop_s          = response_valid && response_ready && !fifo_empty_s;
    assign response_data  = head_s.data;
    assign response_error = head_s.error;

    // Outstanding request counter; simultaneous accept and pop cancel out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            outstanding_r <= '0;
        end else begin
            case ({accept_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + CW'(1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

endmodule

// File: tb/tb_rice_bus_memory_slave.sv
// Directed self-checking bench for rice_bus_memory_slave (default parameters).
module tb_rice_bus_memory_slave;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        request_valid;
    logic        request_ready;
    logic [31:0] request_address;
    logic        request_write;
    logic [31:0] request_data;
    logic [3:0]  request_strobe;
    logic        response_valid;
    logic        response_ready;
    logic [31:0] response_data;
    logic        response_error;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    rice_bus_memory_slave #(
        .XLEN          (32),
        .ADDRESS_WIDTH (32),
        .DEPTH         (1024),
        .BASE_ADDRESS  (32'h0),
        .READ_LATENCY  (1),
        .FIFO_DEPTH    (2)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .request_valid   (request_valid),
        .request_ready   (request_ready),
        .request_address (request_address),
        .request_write   (request_write),
        .request_data    (request_data),
        .request_strobe  (request_strobe),
        .response_valid  (response_valid),
        .response_ready  (response_ready),
        .response_data   (response_data),
        .response_error  (response_error)
    );

    // Present one request (called just after a falling edge), return at the falling edge after accept.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        request_valid = 1'b1; request_address = a; request_write = w; request_data = d; request_strobe = s;
        while (!request_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL issue_timeout addr=%h ready=%b want 1", a, request_ready);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        request_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; request_valid = 1'b0; request_address = '0; request_write = 1'b0;
        request_data = '0; request_strobe = '0; response_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++; if (request_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", request_ready); end
        checks++; if (response_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", response_valid); end
        checks++; if (response_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h want=0", response_data); end
        checks++; if (response_error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b want=0", response_error); end
        i_rst = 1'b0;
        #1;
        checks++; if (request_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", request_ready); end
    endtask

    task automatic test_store_load();
        checks++; if (response_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b want=0", response_valid); end
        issue(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
        checks++; if (response_valid !== 1'b1) begin errors++; $display("FAIL store_latency valid got=%b want=1", response_valid); end
        checks++; if ({response_error, response_data} !== 33'h0) begin errors++; $display("FAIL store_resp got err=%b data=%h want err=0 data=0", response_error, response_data); end
        @(negedge i_clk);
        checks++; if (response_valid !== 1'b0) begin errors++; $display("FAIL store_popped valid got=%b want=0", response_valid); end
        issue(32'h10, 1'b0, 32'h0, 4'hF);
        checks++; if (response_valid !== 1'b1 || response_data !== 32'hDEADBEEF || response_error !== 1'b0) begin
            errors++; $display("FAIL load_10 got v=%b data=%h err=%b want v=1 data=deadbeef err=0", response_valid, response_data, response_error);
        end
        @(negedge i_clk);
    endtask

    task automatic test_strobe();
        issue(32'h20, 1'b1, 32'h11223344, 4'hF);
        issue(32'h20, 1'b1, 32'hAABBCCDD, 4'h2);
        issue(32'h20, 1'b0, 32'h0, 4'h0);
        checks++; if (response_data !== 32'h1122CC44) begin errors++; $display("FAIL strobe_merge got=%h want=1122cc44", response_data); end
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp[0] = 32'hA0A0A0A0; exp[1] = 32'hA4A4A4A4; exp[2] = 32'hA8A8A8A8;
        for (int i = 0; i < 3; i++) issue(32'(4 * i), 1'b1, exp[i], 4'hF);
        @(negedge i_clk);
        request_valid = 1'b1; request_write = 1'b0; request_strobe = 4'hF;
        for (int i = 0; i < 3; i++) begin
            request_address = 32'(4 * i);
            checks++; if (request_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, request_ready); end
            @(posedge i_clk);
            @(negedge i_clk);
            checks++; if (response_valid !== 1'b1 || response_data !== exp[i]) begin
                errors++; $display("FAIL b2b_resp[%0d] got v=%b data=%h want v=1 data=%h", i, response_valid, response_data, exp[i]);
            end
        end
        request_valid = 1'b0;
        @(negedge i_clk);
        checks++; if (response_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b want=0", response_valid); end
        // Back-pressure: two accepts fill the budget.
        response_ready = 1'b0;
        request_valid = 1'b1; request_address = 32'h0;
        @(posedge i_clk); @(negedge i_clk);
        request_address = 32'h4;
        @(posedge i_clk); @(negedge i_clk);
        request_valid = 1'b0;
        checks++; if (request_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got=%b want=0", request_ready); end
        repeat (2) @(negedge i_clk);
        checks++; if (response_valid !== 1'b1 || response_data !== exp[0]) begin
            errors++; $display("FAIL bp_hold got v=%b data=%h want v=1 data=%h", response_valid, response_data, exp[0]);
        end
        response_ready = 1'b1;
        #1;
        checks++; if (request_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_same_cycle got=%b want=0", request_ready); end
        @(negedge i_clk);
        checks++; if (response_valid !== 1'b1 || response_data !== exp[1] || request_ready !== 1'b1) begin
            errors++; $display("FAIL bp_second got v=%b data=%h rdy=%b want v=1 data=%h rdy=1", response_valid, response_data, request_ready, exp[1]);
        end
        @(negedge i_clk);
        checks++; if (response_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b want=0", response_valid); end
    endtask

    task automatic test_range();
        issue(32'h1000, 1'b0, 32'h0, 4'hF);
        checks++; if (response_error !== 1'b1 || response_data !== 32'h0) begin errors++; $display("FAIL range_load got err=%b data=%h want err=1 data=0", response_error, response_data); end
        issue(32'h1000, 1'b1, 32'hFFFFFFFF, 4'hF);
        checks++; if (response_error !== 1'b1 || response_data !== 32'h0) begin errors++; $display("FAIL range_store got err=%b data=%h want err=1 data=0", response_error, response_data); end
        issue(32'h0, 1'b0, 32'h0, 4'hF);
        checks++; if (response_data !== 32'hA0A0A0A0 || response_error !== 1'b0) begin errors++; $display("FAIL range_no_alias got=%h want=a0a0a0a0", response_data); end
        issue(32'hFFC, 1'b1, 32'h12345678, 4'hF);
        issue(32'hFFC, 1'b0, 32'h0, 4'hF);
        checks++; if (response_data !== 32'h12345678 || response_error !== 1'b0) begin errors++; $display("FAIL last_word got=%h err=%b want=12345678 err=0", response_data, response_error); end
        @(negedge i_clk);
    endtask

    task automatic test_same_cycle();
        response_ready = 1'b0;
        issue(32'h4, 1'b0, 32'h0, 4'hF);
        request_valid = 1'b1; request_address = 32'h8; request_write = 1'b0; response_ready = 1'b1;
        #1;
        checks++; if (request_ready !== 1'b1) begin errors++; $display("FAIL sc_ready_before got=%b want=1", request_ready); end
        @(posedge i_clk); @(negedge i_clk);
        request_valid = 1'b0;
        checks++; if (request_ready !== 1'b1 || response_valid !== 1'b1 || response_data !== 32'hA8A8A8A8) begin
            errors++; $display("FAIL sc_after got rdy=%b v=%b data=%h want rdy=1 v=1 data=a8a8a8a8", request_ready, response_valid, response_data);
        end
        @(negedge i_clk);
        checks++; if (response_valid !== 1'b0) begin errors++; $display("FAIL sc_drain got=%b want=0", response_valid); end
    endtask

    task automatic test_reset_midflight();
        response_ready = 1'b0;
        issue(32'h30, 1'b1, 32'h5A5A5A5A, 4'hF);
        issue(32'h8, 1'b0, 32'h0, 4'hF);
        checks++; if (request_ready !== 1'b0 || response_valid !== 1'b1) begin errors++; $display("FAIL mid_full got rdy=%b v=%b want rdy=0 v=1", request_ready, response_valid); end
        i_rst = 1'b1;
        #1;
        checks++; if (response_valid !== 1'b0 || request_ready !== 1'b0) begin errors++; $display("FAIL mid_rst got v=%b rdy=%b want 0 0", response_valid, request_ready); end
        @(negedge i_clk);
        i_rst = 1'b0; response_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            checks++; if (response_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d] got=%b want=0", i, response_valid); end
        end
        issue(32'h30, 1'b0, 32'h0, 4'hF);
        checks++; if (response_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL mid_committed got=%h want=5a5a5a5a", response_data); end
        @(negedge i_clk);
    endtask

    task automatic test_misalign();
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef RICE_BUS_MEMORY_SLAVE_MISALIGN_CHECK_EN
        exp_err = 1'b1; exp_word = 32'hA0A0A0A0;
`else
        exp_err = 1'b0; exp_word = 32'hA0A05678;
`endif
        issue(32'h0, 1'b1, 32'hA0A0A0A0, 4'hF);
        issue(32'h2, 1'b1, 32'h12345678, 4'h3);
        checks++; if (response_error !== exp_err) begin errors++; $display("FAIL misalign_err got=%b want=%b", response_error, exp_err); end
        issue(32'h0, 1'b0, 32'h0, 4'hF);
        checks++; if (response_data !== exp_word) begin errors++; $display("FAIL misalign_mem got=%h want=%h", response_data, exp_word); end
        @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_strobe();
        test_back_to_back();
        test_range();
        test_same_cycle();
        test_reset_midflight();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rice_bus_memory_slave.md
Name: rice_bus_memory_slave

Overview:
- Responder end of the core data bus: a word-organised SRAM model/macro wrapper on the slave side of rice_bus_if.
- Serves load/store requests issued by the core LSU, with a fixed pipelined read latency and a response FIFO that absorbs response back-pressure.
- Used as tightly-coupled data memory in the core subsystem and as the bench memory for core tests.

Parameters:
- XLEN, 32, data width in bits (32 or 64).
- ADDRESS_WIDTH, 32, byte address width on the bus.
- DEPTH, 1024, memory size in XLEN-bit words (power of two).
- BASE_ADDRESS, 0, byte address of word 0.
- READ_LATENCY, 1, cycles from request accept to response entering the FIFO (1..4).
- FIFO_DEPTH, 2, response FIFO entries and maximum outstanding requests (>= 1).

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, asynchronous active-high reset.
- bus_if.request_valid, in, 1, request present.
- bus_if.request_ready, out, 1, request accepted when valid && ready.
- bus_if.request_address, in, ADDRESS_WIDTH, byte address.
- bus_if.request_write, in, 1, 1 = store, 0 = load.
- bus_if.request_data, in, XLEN, store data, lane-aligned.
- bus_if.request_strobe, in, XLEN/8, byte enables.
- bus_if.response_valid, out, 1, response present.
- bus_if.response_ready, in, 1, response consumed when valid && ready.
- bus_if.response_data, out, XLEN, load data; 0 for stores and errors.
- bus_if.response_error, out, 1, access error.

Behaviour:
- Reset: request_ready=0 while i_rst is high, then 1. response_valid=0, response_data=0, response_error=0. Pipeline valids, FIFO pointers and the outstanding counter clear. Memory contents are not reset.
- Reset asserted mid-operation: all in-flight and queued responses are dropped. A store accepted before reset has already been committed to the array.
- Word index = (address - BASE_ADDRESS) >> log2(XLEN/8). Low address bits are ignored for indexing.
- Range error: address < BASE_ADDRESS or index >= DEPTH. The request is not performed and the response has error=1, data=0.
- Store: committed to the array in the accept cycle, bytes per strobe. Strobe=0 is a legal no-op that still produces a response.
- Load: reads the whole word; unenabled lanes are returned as read, not masked.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- Every accepted request produces exactly one response, in order.
- Response latency: response_valid rises exactly READ_LATENCY cycles after accept when the FIFO is empty and response_ready=1. This applies to stores too.
- Pipeline: READ_LATENCY-stage shift register carrying valid, write, error and data. The array read happens in stage 0 (synchronous RAM); later stages delay only.
- Response FIFO: FIFO_DEPTH entries. The head drives the bus outputs directly (registered, no combinational path from request to response).
- Flow control: outstanding counter counts accepted requests whose responses have not been consumed (pipeline plus FIFO). request_ready = !i_rst && (outstanding < FIFO_DEPTH), so the FIFO can never overflow.
- Counter update: +1 on accept, -1 on response handshake, unchanged when both happen in the same cycle.
- Counter boundaries: at outstanding == FIFO_DEPTH, request_ready drops the same cycle. A pop in that cycle does not re-enable ready until the next cycle; no combinational ready-to-ready path.
- FIFO empty: response_valid=0, data and error held at 0.
- FIFO pointers: wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty detection.
- Back-pressure: while response_ready=0, response_valid and its data/error stay stable until the handshake.

Optional Feature:
- Macro: RICE_BUS_MEMORY_SLAVE_MISALIGN_CHECK_EN.
- Defined: a request is misaligned when any set strobe bit lies below address % (XLEN/8). A misaligned request returns error=1, data=0, and a store does not write.
- Undefined: no alignment check; strobes apply as given.

Decomposition:
- rice_bus_pkg holds:
  - rice_bus_response struct (data, error);
  - the pipeline entry struct (valid, write, error, data), parameterised through a type-definition macro keyed on XLEN;
  - the error code constant.
- One sub-module: rice_bus_response_fifo, a synchronous FIFO with depth and type parameters, push/pop, full/empty and a registered head.
- The array, pipeline and counter live in the top module.

Test Plan:
- Reset, then store addr 0x10, data 0xDEADBEEF, strobe 0xF -> response after exactly READ_LATENCY cycles with error=0, data=0. Load 0x10 -> data 0xDEADBEEF.
- Store 0x20 with 0x11223344, then store 0x20 with 0xAABBCCDD, strobe 0x2 -> load 0x20 returns 0x1122CC44.
- Back-to-back loads from 0x0, 0x4, 0x8 with response_ready=1 -> one response per cycle, in order. With response_ready=0, request_ready drops after FIFO_DEPTH accepts and responses are held stable.
- Load from BASE_ADDRESS + 4*DEPTH -> error=1, data=0. Store to that address -> error=1 and no array location modified.
- Accept and response handshake in the same cycle at outstanding = FIFO_DEPTH-1 -> counter unchanged and ready stays 1. Assert i_rst with 2 outstanding -> response_valid=0 immediately, request_ready=0, and no stale responses after release.
- With RICE_BUS_MEMORY_SLAVE_MISALIGN_CHECK_EN: store addr 0x2, strobe 0x3 -> error=1 and memory unchanged. Without the macro: the write occurs and error=0.
